// File: rtl/tick_stopwatch_if.sv
// Bundle of the stopwatch control inputs and readout outputs.
// Handshake: there is no valid/ready pair; every input is sampled on each
// posedge clk and every output is a registered level valid for the whole cycle.
interface tick_stopwatch_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         tick;
  logic         start_stop;
  logic         lap;
  logic         clear;
  logic [W-1:0] count;
  logic [W-1:0] display;
  logic         running;
  logic         lap_hold;
  logic         overflow;
  logic [1:0]   state_dbg;

  // Producer of controls / consumer of readout.
  modport master (
    output tick, start_stop, lap, clear,
    input  count, display, running, lap_hold, overflow, state_dbg
  );

  // The stopwatch itself.
  modport slave (
    input  tick, start_stop, lap, clear,
    output count, display, running, lap_hold, overflow, state_dbg
  );
endinterface

// File: rtl/tick_stopwatch.sv
// BCD stopwatch fed by a one-cycle tick strobe. Ticks are prescaled, then
// accumulated in a DIGITS-wide BCD counter. Start/stop toggles run/pause,
// lap freezes the display, clear returns everything to idle.
module tick_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 2
) (
  input  logic           clk,
  input  logic           reset,
  tick_stopwatch_if.slave sw
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  lap_reg_q, lap_reg_d;
  logic          lap_hold_q, lap_hold_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ss_hist_q, lap_hist_q;

  logic          ss_rise;
  logic          lap_rise;
  logic [W-1:0]  inc_val;
  logic          inc_wrap;

  // Ripple a +1 through the BCD digits; the extra top bit flags all-9s wrap.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // History registers start at 1 so an input held high through reset is not an edge.
  assign ss_rise  = sw.start_stop & ~ss_hist_q;
  assign lap_rise = sw.lap & ~lap_hist_q;
  assign {inc_wrap, inc_val} = bcd_inc(count_q);

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      lap_reg_q  <= '0;
      lap_hold_q <= 1'b0;
      ovf_q      <= 1'b0;
      pre_q      <= '0;
      ss_hist_q  <= 1'b1;
      lap_hist_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lap_reg_q  <= lap_reg_d;
      lap_hold_q <= lap_hold_d;
      ovf_q      <= ovf_d;
      pre_q      <= pre_d;
      ss_hist_q  <= sw.start_stop;
      lap_hist_q <= sw.lap;
    end
  end

  // Next-state: clear wins outright; otherwise FSM, prescaled counting and lap hold.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lap_reg_d  = lap_reg_q;
    lap_hold_d = lap_hold_q;
    ovf_d      = ovf_q;
    pre_d      = pre_q;

    if (sw.clear) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      lap_reg_d  = '0;
      lap_hold_d = 1'b0;
      ovf_d      = 1'b0;
      pre_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (ss_rise) state_d = ST_RUN;
        ST_RUN:   if (ss_rise) state_d = ST_PAUSE;
        ST_PAUSE: if (ss_rise) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase

      // A tick arriving with the stop edge in RUN still counts: decision uses state_q.
      if (state_q == ST_RUN && sw.tick) begin
        if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          count_d = inc_val;
          if (inc_wrap) ovf_d = 1'b1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      // Captured lap value is the pre-increment count.
      if (lap_rise) begin
        if (lap_hold_q) begin
          lap_hold_d = 1'b0;
        end else if (state_q == ST_RUN) begin
          lap_reg_d  = count_q;
          lap_hold_d = 1'b1;
        end
      end
    end
  end

  assign sw.count     = count_q;
  assign sw.display   = lap_hold_q ? lap_reg_q : count_q;
  assign sw.running   = (state_q == ST_RUN);
  assign sw.lap_hold  = lap_hold_q;
  assign sw.overflow  = ovf_q;
  assign sw.state_dbg = state_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch (DIGITS=2, PRESCALE=2). A driver applies inputs on
// negedge and pushes the reference model's expected readout; a monitor pops
// and compares one posedge later.
module tb_tick_stopwatch;
  localparam int DIGITS   = 2;
  localparam int PRESCALE = 2;
  localparam int W        = 4 * DIGITS;
  localparam int EW       = 3 + 2 * W;
  localparam int MAXV     = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tick_stopwatch_if #(.DIGITS(DIGITS)) bus ();

  tick_stopwatch #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .reset (rst_n),
    .sw    (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            total;
  int            bad;
  string         phase;

  // ---------------- reference model ----------------
  int   m_cnt;
  int   m_pre;
  int   m_lapv;
  bit   m_hold;
  bit   m_ovf;
  int   m_mode;
  bit   m_ss_prev;
  bit   m_lap_prev;
  logic ss_lvl;
  logic lap_lvl;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [EW-1:0] model_out();
    return {(m_mode == M_RUN), m_hold, m_ovf, to_bcd(m_cnt),
            to_bcd(m_hold ? m_lapv : m_cnt)};
  endfunction

  task automatic model_reset();
    m_cnt      = 0;
    m_pre      = 0;
    m_lapv     = 0;
    m_hold     = 0;
    m_ovf      = 0;
    m_mode     = M_IDLE;
    m_ss_prev  = 1;
    m_lap_prev = 1;
  endtask

  task automatic model_step(input bit t, input bit ss, input bit lp, input bit clr);
    bit ssr;
    bit lr;
    bit was_run;
    ssr = ss & !m_ss_prev;
    lr  = lp & !m_lap_prev;
    m_ss_prev  = ss;
    m_lap_prev = lp;
    if (clr) begin
      m_cnt  = 0;
      m_pre  = 0;
      m_lapv = 0;
      m_hold = 0;
      m_ovf  = 0;
      m_mode = M_IDLE;
    end else begin
      was_run = (m_mode == M_RUN);
      if (lr) begin
        if (m_hold) m_hold = 0;
        else if (was_run) begin
          m_lapv = m_cnt;
          m_hold = 1;
        end
      end
      if (was_run && t) begin
        m_pre++;
        if (m_pre == PRESCALE) begin
          m_pre = 0;
          m_cnt++;
          if (m_cnt == MAXV) begin
            m_cnt = 0;
            m_ovf = 1;
          end
        end
      end
      if (ssr) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic step(input logic t, input logic ss, input logic lp, input logic clr);
    bus.tick       = t;
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clear      = clr;
    model_step(t, ss, lp, clr);
    exp_q.push_back(model_out());
    name_q.push_back(phase);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1, ss_lvl, lap_lvl, 1'b0);
      step(1'b0, ss_lvl, lap_lvl, 1'b0);
    end
  endtask

  task automatic press_ss();
    step(1'b0, 1'b1, lap_lvl, 1'b0);
    step(1'b0, 1'b0, lap_lvl, 1'b0);
    ss_lvl = 1'b0;
  endtask

  task automatic press_lap();
    step(1'b0, ss_lvl, 1'b1, 1'b0);
    step(1'b0, ss_lvl, 1'b0, 1'b0);
    lap_lvl = 1'b0;
  endtask

  task automatic do_clear();
    step(1'b0, ss_lvl, lap_lvl, 1'b1);
    step(1'b0, ss_lvl, lap_lvl, 1'b0);
  endtask

  // Direct comparison against a fixed value from the block's documented behaviour.
  task automatic expect_now(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.running, bus.lap_hold, bus.overflow, bus.count, bus.display};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got run/hold/ovf/count/disp=%0h want=%0h", nm, a, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    total   = 0;
    bad     = 0;
    ss_lvl  = 1'b0;
    lap_lvl = 1'b0;
    phase   = "reset";
    rst_n          = 1'b0;
    bus.tick       = 1'b0;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    expect_now("reset_outputs",
               32'({bus.running, bus.lap_hold, bus.overflow, bus.count, bus.display}), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "start_count";
    press_ss();
    ticks(6);
    expect_now("count_after_6", 32'(bus.count), 32'h03);
    expect_now("running_on", 32'(bus.running), 32'd1);
    expect_now("no_overflow", 32'(bus.overflow), 32'd0);

    phase = "wrap";
    ticks(192);
    expect_now("count_99", 32'(bus.count), 32'h99);
    ticks(2);
    expect_now("wrap_count", 32'(bus.count), 32'h00);
    expect_now("wrap_overflow", 32'(bus.overflow), 32'd1);
    do_clear();
    expect_now("clear_overflow", 32'(bus.overflow), 32'd0);
    expect_now("clear_idle", 32'(bus.running), 32'd0);

    phase = "lap";
    press_ss();
    ticks(10);
    press_lap();
    ticks(4);
    expect_now("lap_display", 32'(bus.display), 32'h05);
    expect_now("lap_count", 32'(bus.count), 32'h07);
    press_lap();
    expect_now("lap_release", 32'(bus.display), 32'h07);

    phase = "pause_prescale";
    do_clear();
    press_ss();
    ticks(3);
    press_ss();
    ticks(2);
    expect_now("paused_count", 32'(bus.count), 32'h01);
    press_ss();
    ticks(1);
    expect_now("partial_prescale", 32'(bus.count), 32'h02);

    phase = "tick_and_stop";
    ticks(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("tick_stop_count", 32'(bus.count), 32'h03);
    expect_now("tick_stop_paused", 32'(bus.running), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("clear_ss_count", 32'(bus.count), 32'h00);
    expect_now("clear_ss_idle", 32'(bus.running), 32'd0);

    phase = "async_reset";
    press_ss();
    ticks(5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.start_stop = 1'b1;
    #1;
    expect_now("async_reset_outputs",
               32'({bus.running, bus.lap_hold, bus.overflow, bus.count, bus.display}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phase = "ss_held_reset";
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_now("ss_held_no_start", 32'(bus.running), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    press_ss();
    expect_now("start_after_release", 32'(bus.running), 32'd1);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      logic t;
      logic clr;
      t   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0)  ss_lvl  = ~ss_lvl;
      if ($urandom_range(0, 11) == 0) lap_lvl = ~lap_lvl;
      step(t, ss_lvl, lap_lvl, clr);
    end

    phase = "drain";
    repeat (3) @(posedge clk);
    #2;
    expect_now("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
